perspective_correct: RTL and testbench

Perspective-correction stage placed directly downstream of the rasterizer's per-pixel attribute interpolation. It accepts interpolated 1/w, u/w and v/w for one pixel and obtains w by driving an external reciprocal unit through a start/done handshake. It multiplies u/w and v/w by w and emits perspective-correct u and v, with a passthrough tag, to the texture sampler. All values are signed Q18.14 fixed point.

---
 rtl/perspective_correct.sv | 169 ++++++++++++++++
 tb/tb_perspective_correct.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perspective_correct.sv
// Perspective-correction stage: takes interpolated 1/w, u/w, v/w, fetches w from an
// external reciprocal unit and emits u = (u/w)*w and v = (v/w)*w in saturated Q18.14.
module perspective_correct #(
    parameter int FRAC_BITS = 14,
    parameter int TAG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          inv_w_i,
    input  logic [31:0]          u_w_i,
    input  logic [31:0]          v_w_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 recip_start_o,
    output logic [31:0]          recip_x_o,
    input  logic [31:0]          recip_z_i,
    input  logic                 recip_done_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [31:0]          u_o,
    output logic [31:0]          v_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_MUL_U = 3'd3,
        S_MUL_V = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    // Arithmetic shift back to Q18.14, then clamp into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic signed [63:0] prod);
        logic signed [63:0] shifted;
        shifted = prod >>> FRAC_BITS;
        if (shifted > 64'sh0000_0000_7FFF_FFFF) begin
            sat32 = 32'h7FFF_FFFF;
        end else if (shifted < 64'shFFFF_FFFF_8000_0000) begin
            sat32 = 32'h8000_0000;
        end else begin
            sat32 = shifted[31:0];
        end
    endfunction

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic                   r_start;
    logic [31:0]            r_inv_w;
    logic [31:0]            r_u_w;
    logic [31:0]            r_v_w;
    logic [31:0]            r_w;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic                   r_valid;
    logic [31:0]            r_u;
    logic [31:0]            r_v;
    logic [TAG_WIDTH-1:0]   r_tag_o;
    logic [31:0]            w_mul_a;
    logic signed [63:0]     w_mul_a_ext;
    logic signed [63:0]     w_mul_b_ext;
    logic signed [63:0]     w_prod;

    // Ready must drop combinationally with reset so it reads 0 during reset and 1 right after.
    assign ready_o  = (r_state == S_IDLE) && !reset_i;
    assign w_accept = valid_i && ready_o;

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_START;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (recip_done_i) begin
                    w_next = S_MUL_U;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_MUL_U: begin
                w_next = S_MUL_V;
            end
            S_MUL_V: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (ready_i) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_OUT;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // One shared multiplier: u/w in MUL_U, v/w in MUL_V.
    always_comb begin
        w_mul_a = r_u_w;
        if (r_state == S_MUL_V) begin
            w_mul_a = r_v_w;
        end else begin
            w_mul_a = r_u_w;
        end
    end

    assign w_mul_a_ext = {{32{w_mul_a[31]}}, w_mul_a};
    assign w_mul_b_ext = {{32{r_w[31]}}, r_w};
    assign w_prod      = w_mul_a_ext * w_mul_b_ext;

    // State register, operand capture, reciprocal handshake and result registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_inv_w <= 32'd0;
            r_u_w   <= 32'd0;
            r_v_w   <= 32'd0;
            r_w     <= 32'd0;
            r_tag   <= {TAG_WIDTH{1'b0}};
            r_valid <= 1'b0;
            r_u     <= 32'd0;
            r_v     <= 32'd0;
            r_tag_o <= {TAG_WIDTH{1'b0}};
        end else begin
            r_state <= w_next;
            r_start <= w_accept;
            r_valid <= (w_next == S_OUT);
            if (w_accept) begin
                r_inv_w <= inv_w_i;
                r_u_w   <= u_w_i;
                r_v_w   <= v_w_i;
                r_tag   <= tag_i;
            end
            // Done is only meaningful while waiting; stray pulses elsewhere are dropped.
            if ((r_state == S_WAIT) && recip_done_i) begin
                r_w <= recip_z_i;
            end
            if (r_state == S_MUL_U) begin
                r_u <= sat32(w_prod);
            end
            if (r_state == S_MUL_V) begin
                r_v     <= sat32(w_prod);
                r_tag_o <= r_tag;
            end
        end
    end

    assign recip_start_o = r_start;
    assign recip_x_o     = r_inv_w;
    assign valid_o       = r_valid;
    assign u_o           = r_u;
    assign v_o           = r_v;
    assign tag_o         = r_tag_o;

endmodule

// File: tb/tb_perspective_correct.sv
// Directed self-checking bench for perspective_correct with a behavioural
// reciprocal unit that answers a programmable number of cycles after each start.
module tb_perspective_correct;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] inv_w_i = 32'd0;
    logic [31:0] u_w_i = 32'd0;
    logic [31:0] v_w_i = 32'd0;
    logic [31:0] tag_i = 32'd0;
    logic        recip_start_o;
    logic [31:0] recip_x_o;
    logic [31:0] recip_z_i;
    logic        recip_done_i;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] u_o;
    logic [31:0] v_o;
    logic [31:0] tag_o;

    int          n_checks = 0;
    int          n_pass = 0;

    // reciprocal model
    int          rec_d = 5;
    logic [31:0] model_z = 32'd0;
    int          rec_cnt = 0;
    logic        rec_done = 1'b0;
    logic [31:0] rec_z = 32'd0;
    int          start_cnt = 0;
    logic        man_done = 1'b0;
    logic [31:0] man_z = 32'd0;

    assign recip_done_i = rec_done | man_done;
    assign recip_z_i    = man_done ? man_z : rec_z;

    perspective_correct #(.FRAC_BITS(14), .TAG_WIDTH(32)) dut (
        .clk(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .inv_w_i(inv_w_i), .u_w_i(u_w_i), .v_w_i(v_w_i), .tag_i(tag_i),
        .recip_start_o(recip_start_o), .recip_x_o(recip_x_o),
        .recip_z_i(recip_z_i), .recip_done_i(recip_done_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .u_o(u_o), .v_o(v_o), .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    // Done arrives rec_d cycles after the cycle holding the start pulse.
    always @(negedge clk) begin
        rec_done <= 1'b0;
        if (recip_start_o) begin
            start_cnt <= start_cnt + 1;
            rec_cnt   <= rec_d;
        end else if (rec_cnt > 0) begin
            rec_cnt <= rec_cnt - 1;
            if (rec_cnt == 1) begin
                rec_done <= 1'b1;
                rec_z    <= model_z;
            end
        end
    end

    task automatic launch(input logic [31:0] inv, input logic [31:0] uw,
                          input logic [31:0] vw, input logic [31:0] tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready_o) break;
        end
        valid_i = 1'b1;
        inv_w_i = inv;
        u_w_i   = uw;
        v_w_i   = vw;
        tag_i   = tag;
    endtask

    // Returns k = cycle (after accept) of first valid_o, or -1 on timeout.
    task automatic run_pixel(input int pulse_at, input logic [31:0] pz, output int k,
                             output logic st1, output logic [31:0] x1);
        k = -1;
        st1 = 1'b0;
        x1 = 32'd0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) begin
                valid_i = 1'b0;
                st1 = recip_start_o;
                x1 = recip_x_o;
            end
            if (i == pulse_at) begin
                man_done = 1'b1;
                man_z = pz;
            end else begin
                man_done = 1'b0;
            end
            if (valid_o) begin
                k = i;
                break;
            end
        end
        man_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (recip_start_o !== 1'b0) $display("FAIL reset_start: got %b want 0", recip_start_o); else n_pass++;
        n_checks++; if (recip_x_o !== 32'd0) $display("FAIL reset_x: got %h want 0", recip_x_o); else n_pass++;
        n_checks++; if ({u_o, v_o, tag_o} !== 96'd0) $display("FAIL reset_data: got %h %h %h want 0", u_o, v_o, tag_o); else n_pass++;
        reset_i = 1'b0;
        @(negedge clk);
        n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", ready_o); else n_pass++;
    endtask

    task automatic test_basic();
        int k; logic st; logic [31:0] x; int s0;
        rec_d = 5; model_z = 32'h0000_8000; s0 = start_cnt;
        launch(32'h0000_2000, 32'h0000_6000, 32'hFFFF_E000, 32'h0000_00A5);
        run_pixel(0, 32'd0, k, st, x);
        n_checks++; if (st !== 1'b1) $display("FAIL basic_start: got %b want 1", st); else n_pass++;
        n_checks++; if (x !== 32'h0000_2000) $display("FAIL basic_x: got %h want 00002000", x); else n_pass++;
        n_checks++; if (k != 9) $display("FAIL basic_latency: got %0d want 9", k); else n_pass++;
        n_checks++; if (u_o !== 32'h0000_C000) $display("FAIL basic_u: got %h want 0000c000", u_o); else n_pass++;
        n_checks++; if (v_o !== 32'hFFFF_C000) $display("FAIL basic_v: got %h want ffffc000", v_o); else n_pass++;
        n_checks++; if (tag_o !== 32'h0000_00A5) $display("FAIL basic_tag: got %h want 000000a5", tag_o); else n_pass++;
        @(negedge clk);
        n_checks++; if ({ready_o, valid_o} !== 2'b10) $display("FAIL basic_after: got ready/valid %b want 10", {ready_o, valid_o}); else n_pass++;
        n_checks++; if (start_cnt - s0 != 1) $display("FAIL basic_starts: got %0d want 1", start_cnt - s0); else n_pass++;
    endtask

    task automatic test_saturation();
        int k; logic st; logic [31:0] x;
        rec_d = 3; model_z = 32'h0000_8000;
        launch(32'h0000_2000, 32'h7FFF_0000, 32'h8001_0000, 32'h0000_0011);
        run_pixel(0, 32'd0, k, st, x);
        n_checks++; if (u_o !== 32'h7FFF_FFFF) $display("FAIL sat_u: got %h want 7fffffff", u_o); else n_pass++;
        n_checks++; if (v_o !== 32'h8000_0000) $display("FAIL sat_v: got %h want 80000000", v_o); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int k; logic st; logic [31:0] x; int s0; logic bad;
        rec_d = 2; model_z = 32'h0000_8000; s0 = start_cnt; bad = 1'b0;
        ready_i = 1'b0;
        launch(32'h0000_4000, 32'h0000_1000, 32'h0000_2000, 32'h0000_0077);
        run_pixel(0, 32'd0, k, st, x);
        n_checks++; if (k != 6) $display("FAIL bp_latency: got %0d want 6", k); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1; tag_i = 32'h0000_00EE; u_w_i = 32'h1234_5678;
            @(negedge clk);
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || u_o !== 32'h0000_2000 ||
                v_o !== 32'h0000_4000 || tag_o !== 32'h0000_0077) bad = 1'b1;
        end
        n_checks++; if (bad) $display("FAIL bp_hold: got u=%h v=%h tag=%h rdy=%b want 2000 4000 77 0", u_o, v_o, tag_o, ready_o); else n_pass++;
        valid_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({ready_o, valid_o} !== 2'b10) $display("FAIL bp_release: got ready/valid %b want 10", {ready_o, valid_o}); else n_pass++;
        n_checks++; if (start_cnt - s0 != 1) $display("FAIL bp_starts: got %0d want 1", start_cnt - s0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nacc; int nout; int accc[3]; logic [31:0] gu[3]; logic [31:0] gt[3];
        int s0; logic pend;
        rec_d = 1; model_z = 32'h0000_4000; ready_i = 1'b1;
        nacc = 0; nout = 0; pend = 1'b0; s0 = start_cnt;
        @(negedge clk);
        valid_i = 1'b1; inv_w_i = 32'h0000_4000; u_w_i = 32'h0000_0100; v_w_i = 32'd0; tag_i = 32'd1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (pend) begin
                    pend = 1'b0;
                    if (nacc < 3) begin
                        u_w_i = 32'h0000_0100 * (nacc + 1);
                        tag_i = nacc + 1;
                    end else begin
                        valid_i = 1'b0;
                    end
                end
            end
            if (valid_o && nout < 3) begin
                gu[nout] = u_o; gt[nout] = tag_o; nout++;
            end
            if (valid_i && ready_o && nacc < 3) begin
                accc[nacc] = c; nacc++; pend = 1'b1;
            end
            if (nout == 3) break;
        end
        valid_i = 1'b0;
        n_checks++; if (nout != 3 || nacc != 3) $display("FAIL b2b_count: got %0d out %0d acc want 3 3", nout, nacc); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            if (j < nout) begin
                n_checks++; if (gt[j] !== j + 1) $display("FAIL b2b_tag%0d: got %h want %h", j, gt[j], j + 1); else n_pass++;
                n_checks++; if (gu[j] !== 32'h0000_0100 * (j + 1)) $display("FAIL b2b_u%0d: got %h want %h", j, gu[j], 32'h0000_0100 * (j + 1)); else n_pass++;
            end
        end
        if (nacc == 3) begin
            n_checks++; if (accc[1] - accc[0] != 6) $display("FAIL b2b_space1: got %0d want 6", accc[1] - accc[0]); else n_pass++;
            n_checks++; if (accc[2] - accc[1] != 6) $display("FAIL b2b_space2: got %0d want 6", accc[2] - accc[1]); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (start_cnt - s0 != 3) $display("FAIL b2b_starts: got %0d want 3", start_cnt - s0); else n_pass++;
    endtask

    task automatic test_spurious_done();
        int k; logic st; logic [31:0] x;
        @(negedge clk);
        man_done = 1'b1; man_z = 32'h0000_DEAD;
        @(negedge clk);
        man_done = 1'b0;
        n_checks++; if ({ready_o, valid_o} !== 2'b10) $display("FAIL spur_idle: got ready/valid %b want 10", {ready_o, valid_o}); else n_pass++;
        rec_d = 2; model_z = 32'h0000_4000;
        launch(32'h0000_4000, 32'h0000_1000, 32'h0000_2000, 32'h0000_0042);
        run_pixel(4, 32'h0001_0000, k, st, x);
        n_checks++; if (k != 6) $display("FAIL spur_latency: got %0d want 6", k); else n_pass++;
        n_checks++; if (u_o !== 32'h0000_1000) $display("FAIL spur_u: got %h want 00001000", u_o); else n_pass++;
        n_checks++; if (v_o !== 32'h0000_2000) $display("FAIL spur_v: got %h want 00002000", v_o); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int s0; logic bad;
        rec_d = 20; model_z = 32'h0000_4000; s0 = start_cnt; bad = 1'b0;
        launch(32'h0000_4000, 32'h0000_1000, 32'h0000_1000, 32'h0000_0055);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) valid_i = 1'b0;
            if (i == 3) reset_i = 1'b1;
            if (i == 4) begin
                n_checks++; if ({ready_o, valid_o, recip_start_o} !== 3'b000 || recip_x_o !== 32'd0)
                    $display("FAIL rstwait_outputs: got rdy/val/st %b x=%h want 000 0", {ready_o, valid_o, recip_start_o}, recip_x_o); else n_pass++;
            end
            if (i == 5) reset_i = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (ready_o !== 1'b1) $display("FAIL rstwait_ready: got %b want 1", ready_o); else n_pass++;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid_o !== 1'b0 || ready_o !== 1'b1) bad = 1'b1;
        end
        n_checks++; if (bad) $display("FAIL rstwait_late_done: got valid/ready %b%b want 01", valid_o, ready_o); else n_pass++;
        n_checks++; if (start_cnt - s0 != 1) $display("FAIL rstwait_starts: got %0d want 1", start_cnt - s0); else n_pass++;
    endtask

    task automatic test_zero_inv();
        int k; logic st; logic [31:0] x;
        rec_d = 4; model_z = 32'h0040_0000;
        launch(32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 32'h0000_0099);
        run_pixel(0, 32'd0, k, st, x);
        n_checks++; if (k != 8) $display("FAIL zero_latency: got %0d want 8", k); else n_pass++;
        n_checks++; if (x !== 32'd0 || st !== 1'b1) $display("FAIL zero_start: got st=%b x=%h want 1 0", st, x); else n_pass++;
        n_checks++; if (u_o !== 32'h0040_0000) $display("FAIL zero_u: got %h want 00400000", u_o); else n_pass++;
        n_checks++; if (tag_o !== 32'h0000_0099) $display("FAIL zero_tag: got %h want 00000099", tag_o); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_spurious_done();
        test_reset_in_wait();
        test_zero_inv();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
